// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder end of the MEM-stage data bus. Serves 16-bit read/write requests
// on a byte-addressed bus from an internal word array, with a fixed number of
// wait states and a one-cycle ready pulse. The shared data bus is driven by
// this block only during the response cycle of a read.
//
// Ports:
//   clk                single clock, rising-edge active
//   rst                asynchronous reset, active-high
//   Memory_addressbus  byte address; bit 0 set means misaligned
//   Memory_databus     write data from the CPU / read data to the CPU
//   Memory_writemode   1 = write, 0 = read; sampled with the request
//   Memory_request     transaction strobe, held by the CPU until ready
//   Memory_ready       one-cycle completion pulse
//   Memory_misaligned  error flag, valid only while Memory_ready = 1
//
// WAIT_CYCLES must lie in 0..15 (the wait counter is 4 bits wide).
// MEM_WORDS must equal 2**(ADDR_W-1).

module data_memory_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_WORDS   = 2048,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Memory_addressbus,
  inout  wire  [DATA_W-1:0] Memory_databus,
  input  logic              Memory_writemode,
  input  logic              Memory_request,
  output logic              Memory_ready,
  output logic              Memory_misaligned
);

  localparam int unsigned IdxW     = ADDR_W - 1;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [3:0]        r_count;
  logic [IdxW-1:0]   r_widx;
  logic              r_write;
  logic              r_mis;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  // Zeroed at elaboration only; reset deliberately leaves the contents alone.
  logic [DATA_W-1:0] r_mem [MEM_WORDS] = '{default: '0};

  logic            w_accept;
  logic            w_enter_resp;
  logic [IdxW-1:0] w_ridx;
  logic            w_rmis;
  logic            w_drive;

  // Next-state and outputs.
  always_comb begin
    w_state_next      = r_state;
    w_accept          = 1'b0;
    Memory_ready      = 1'b0;
    Memory_misaligned = 1'b0;
    w_drive           = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (Memory_request) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (r_count == 4'd1) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        Memory_ready      = 1'b1;
        Memory_misaligned = r_mis;
        w_drive           = ~r_write;
        w_state_next      = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so the read
  // index has to come from the live bus rather than the latched copy.
  always_comb begin
    w_enter_resp = (w_state_next == StResp) && (r_state != StResp);
    if (r_state == StIdle) begin
      w_ridx = Memory_addressbus[ADDR_W-1:1];
      w_rmis = Memory_addressbus[0];
    end else begin
      w_ridx = r_widx;
      w_rmis = r_mis;
    end
  end

  assign Memory_databus = w_drive ? r_rdata : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
      r_widx  <= '0;
      r_write <= 1'b0;
      r_mis   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_widx  <= Memory_addressbus[ADDR_W-1:1];
        r_write <= Memory_writemode;
        r_mis   <= Memory_addressbus[0];
        r_count <= WaitLoad;
        if (Memory_writemode) begin
          r_wdata <= Memory_databus;
        end
      end else if (r_state == StWait) begin
        r_count <= r_count - 4'd1;
      end

      // Misaligned reads return zero and never touch the array.
      if (w_enter_resp) begin
        r_rdata <= w_rmis ? '0 : r_mem[w_ridx];
      end
    end
  end

  // Write commits on the edge that ends RESP; an async reset before that
  // edge leaves the state in IDLE, so an aborted write is never committed.
  always_ff @(posedge clk) begin
    if (r_state == StResp && r_write && !r_mis) begin
      r_mem[r_widx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances with WAIT_CYCLES = 1, 0, 15.
// A pull-up on each bus makes an undriven (high-Z) bus read as all ones.

module tb_data_memory_responder;

  localparam logic [15:0] HIZ = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req  [3];
  logic        wr   [3];
  logic        drv  [3];
  logic [11:0] addr [3];
  logic [15:0] wd   [3];

  wire [15:0] bus0, bus1, bus2;
  wire        rdy0, rdy1, rdy2;
  wire        mis0, mis1, mis2;

  pullup pu_bus0 (bus0);
  pullup pu_bus1 (bus1);
  pullup pu_bus2 (bus2);

  assign bus0 = drv[0] ? wd[0] : 16'hzzzz;
  assign bus1 = drv[1] ? wd[1] : 16'hzzzz;
  assign bus2 = drv[2] ? wd[2] : 16'hzzzz;

  logic [15:0] bus_v [3];
  logic        rdy_v [3];
  logic        mis_v [3];

  always_comb begin
    bus_v[0] = bus0;
    bus_v[1] = bus1;
    bus_v[2] = bus2;
    rdy_v[0] = rdy0;
    rdy_v[1] = rdy1;
    rdy_v[2] = rdy2;
    mis_v[0] = mis0;
    mis_v[1] = mis1;
    mis_v[2] = mis2;
  end

  data_memory_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk              (clk),
    .rst              (rst),
    .Memory_addressbus(addr[0]),
    .Memory_databus   (bus0),
    .Memory_writemode (wr[0]),
    .Memory_request   (req[0]),
    .Memory_ready     (rdy0),
    .Memory_misaligned(mis0)
  );

  data_memory_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk              (clk),
    .rst              (rst),
    .Memory_addressbus(addr[1]),
    .Memory_databus   (bus1),
    .Memory_writemode (wr[1]),
    .Memory_request   (req[1]),
    .Memory_ready     (rdy1),
    .Memory_misaligned(mis1)
  );

  data_memory_responder #(.WAIT_CYCLES(15)) u_w15 (
    .clk              (clk),
    .rst              (rst),
    .Memory_addressbus(addr[2]),
    .Memory_databus   (bus2),
    .Memory_writemode (wr[2]),
    .Memory_request   (req[2]),
    .Memory_ready     (rdy2),
    .Memory_misaligned(mis2)
  );

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One CPU transaction. For a read, data is the expected read word; for a
  // write it is the write data and the bus must stay high-Z during RESP.
  task automatic transact(input int d, input logic [11:0] a, input logic w,
                          input logic [15:0] data, input logic exp_m, input int exp_lat,
                          input string tag);
    exp_t e;
    int   k;
    logic seen;
    e.tag  = tag;
    e.data = w ? HIZ : (exp_m ? 16'h0000 : data);
    e.mis  = exp_m;
    e.lat  = exp_lat;
    sb.push_back(e);

    @(posedge clk);
    #1;
    addr[d] = a;
    wr[d]   = w;
    wd[d]   = data;
    drv[d]  = w;
    req[d]  = 1'b1;
    @(negedge clk);
    chk({tag, "/pre_ready"}, 16'(rdy_v[d]), 16'd0);
    if (!w) chk({tag, "/pre_bus"}, bus_v[d], HIZ);

    @(posedge clk);  // accepting edge
    #1;
    drv[d] = 1'b0;
    k      = 0;
    seen   = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = rdy_v[d];
    end
    req[d] = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "/ready_seen"}, 16'(seen), 16'd1);
    chk({e.tag, "/latency"}, 16'(k), 16'(e.lat));
    chk({e.tag, "/misaligned"}, 16'(mis_v[d]), 16'(e.mis));
    chk({e.tag, "/resp_bus"}, bus_v[d], e.data);

    @(negedge clk);
    chk({e.tag, "/post_ready"}, 16'(rdy_v[d]), 16'd0);
    chk({e.tag, "/post_mis"}, 16'(mis_v[d]), 16'd0);
    chk({e.tag, "/post_bus"}, bus_v[d], HIZ);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [11:0] nxt;
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      wr[i]   = 1'b0;
      drv[i]  = 1'b0;
      addr[i] = '0;
      wd[i]   = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d/ready", i), 16'(rdy_v[i]), 16'd0);
      chk($sformatf("reset%0d/mis", i), 16'(mis_v[i]), 16'd0);
      chk($sformatf("reset%0d/bus", i), bus_v[i], HIZ);
    end
    rst = 1'b0;

    // WAIT_CYCLES = 1
    transact(0, 12'h010, 1'b1, 16'hBEEF, 1'b0, 2, "w1_wr_beef");
    transact(0, 12'h010, 1'b0, 16'hBEEF, 1'b0, 2, "w1_rd_beef");
    transact(0, 12'h011, 1'b0, 16'h0000, 1'b1, 2, "w1_rd_mis");
    transact(0, 12'h011, 1'b1, 16'h1234, 1'b1, 2, "w1_wr_mis");
    transact(0, 12'h010, 1'b0, 16'hBEEF, 1'b0, 2, "w1_rd_after_mis");
    transact(0, 12'h012, 1'b1, 16'h5A5A, 1'b0, 2, "w1_wr_5a5a");
    transact(0, 12'h012, 1'b0, 16'h5A5A, 1'b0, 2, "w1_rd_5a5a");

    // WAIT_CYCLES = 0
    transact(1, 12'h000, 1'b0, 16'h0000, 1'b0, 1, "w0_rd_zero");
    transact(1, 12'h004, 1'b1, 16'hC3C3, 1'b0, 1, "w0_wr_c3c3");
    transact(1, 12'h004, 1'b0, 16'hC3C3, 1'b0, 1, "w0_rd_c3c3");

    // WAIT_CYCLES = 15
    transact(2, 12'h000, 1'b0, 16'h0000, 1'b0, 16, "w15_rd_zero");
    transact(2, 12'h006, 1'b1, 16'h7E57, 1'b0, 16, "w15_wr_7e57");
    transact(2, 12'h006, 1'b0, 16'h7E57, 1'b0, 16, "w15_rd_7e57");

    // Reset during WAIT of a write: no ready, write never commits.
    @(posedge clk);
    #1;
    addr[0] = 12'h020;
    wr[0]   = 1'b1;
    wd[0]   = 16'hAAAA;
    drv[0]  = 1'b1;
    req[0]  = 1'b1;
    @(posedge clk);
    #1;
    drv[0] = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid/ready", 16'(rdy_v[0]), 16'd0);
    chk("rst_mid/bus", bus_v[0], HIZ);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid/no_ready%0d", i), 16'(rdy_v[0]), 16'd0);
    end
    transact(0, 12'h020, 1'b0, 16'h0000, 1'b0, 2, "w1_rd_after_rst");

    // Held request, alternating 0x010/0x012; address scrambled during WAIT.
    @(posedge clk);
    #1;
    addr[0] = 12'h010;
    wr[0]   = 1'b0;
    req[0]  = 1'b1;
    e.tag = "held";
    e.data = 16'hBEEF;
    e.mis = 1'b0;
    e.lat = 2;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      nxt = (i % 2 == 0) ? 12'h012 : 12'h010;
      @(posedge clk);  // accept
      #1;
      addr[0] = nxt;   // must not affect the word already latched
      @(negedge clk);
      chk($sformatf("held%0d/wait_ready", i), 16'(rdy_v[0]), 16'd0);
      @(negedge clk);
      chk($sformatf("held%0d/ready", i), 16'(rdy_v[0]), 16'd1);
      e = sb.pop_front();
      chk($sformatf("held%0d/data", i), bus_v[0], e.data);
      if (i < 3) begin
        e.data = (nxt == 12'h010) ? 16'hBEEF : 16'h5A5A;
        sb.push_back(e);
      end else begin
        req[0] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("held%0d/gap_ready", i), 16'(rdy_v[0]), 16'd0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
